tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Programmable melody player for the buzzer output. It holds a small sequence RAM of note
//  entries and steps through them, producing a square wave at each note's pitch for the
//  programmed duration. Notes are separated by a silent articulation gap.
//  Supports one-shot and loop modes, start/stop control and busy/done status.
//  Replaces the fixed 7-note scale generator and is driven by the game controller for event sounds.
// PARAMETERS
//  DIV_W     16      width of half-period counter
//  DUR_W     12      width of per-note duration field, in ticks
//  TICK_DIV  100000  clk cycles per duration tick (1 ms at 100 MHz)
//  GAP_TICKS 10      silent ticks after every note (0 = no gap)
//  AW        4       sequence address width; DEPTH = 2**AW entries
//  EW = 4+DUR_W      derived entry width: {oct_up[1], note[2:0], dur[DUR_W-1:0]}
// PORTS
//  clk       in   1    system clock
//  rst_n     in   1    asynchronous active-low reset
//  wr_en     in   1    write wr_data into sequence RAM at wr_addr
//  wr_addr   in   AW   RAM write address
//  wr_data   in   EW   note entry
//  last_addr in   AW   index of final entry of the sequence
//  loop_en   in   1    1 = restart at entry 0 after last_addr
//  start     in   1    begin playback from entry 0 (pulse)
//  stop      in   1    abort playback (pulse)
//  busy      out  1    high from LOAD through end of sequence
//  done      out  1    1-cycle pulse on normal one-shot completion
//  cur_addr  out  AW   entry currently loaded/playing
//  beep      out  1    square-wave buzzer drive
// BEHAVIOUR
//  Reset: state IDLE; beep=0, busy=0, done=0, cur_addr=0; all counters 0. RAM contents are not reset.
//  Note table, half-period in clk cycles:
//   note 0 = rest (beep held 0); 1=47774, 2=42568, 3=37919, 4=35791, 5=31888, 6=28410, 7=25309.
//   oct_up=1 uses half-period>>1 (one octave up). Rest is unaffected by oct_up.
//  FSM: IDLE -> LOAD -> PLAY -> GAP -> (LOAD | IDLE).
//  IDLE: start=1 -> LOAD next cycle with cur_addr=0 and busy=1.
//  LOAD (1 cycle): read RAM[cur_addr] (registered); latch half-period and dur; clear cnt, tick_cnt, dur_cnt.
//   Then go to PLAY. If dur==0, skip PLAY and go to GAP.
//  PLAY: cnt counts 0..half-1; at half-1 toggle beep, cnt<=0. First toggle comes half cycles after PLAY entry.
//   Tick = tick_cnt reaching TICK_DIV-1, after which tick_cnt wraps to 0.
//   dur_cnt increments on each tick; on the tick where dur_cnt==dur-1 -> GAP.
//  GAP: beep forced 0 on entry. After GAP_TICKS ticks (0 = zero cycles) advance:
//   cur_addr!=last_addr -> cur_addr+1, LOAD.
//   cur_addr==last_addr & loop_en -> cur_addr=0, LOAD. loop_en is sampled only at this point.
//   cur_addr==last_addr & !loop_en -> IDLE, busy=0, done=1 for that one cycle.
//  Per-note busy time: 1 + (dur+GAP_TICKS)*TICK_DIV cycles.
//  stop=1 in any state -> IDLE next cycle, beep=0, busy=0, no done pulse. stop has priority over start.
//  start while busy is ignored.
//  wr_en is accepted in every state. A write to the entry being played takes effect at its next LOAD.
//   A write and a LOAD read of the same address in the same cycle returns the old data.
//  last_addr is sampled live. If changed mid-play below cur_addr, playback runs to the address wrap and continues.
//  Async reset mid-play: outputs go to reset values immediately, without waiting for clk.
// TESTING (bench overrides TICK_DIV=100, GAP_TICKS=2)
//  1 RAM[0]={0,1,3}, last_addr=0, loop_en=0, start -> beep toggles every 47774 cycles through PLAY (300 cycles,
//    so no toggle: use dur=3 with TICK_DIV=50000 -> 3 toggles); busy high 1+(3+2)*TICK_DIV cycles; done coincides with busy fall.
//  2 RAM[0]={1,1,2}, TICK_DIV=50000 -> toggles every 23887 cycles (4 toggles in 100000 cycles).
//  3 RAM[0]={0,0,5} (rest) -> beep stays 0 for all 701 busy cycles; done pulses once.
//  4 last_addr=1, loop_en=1 -> cur_addr sequence 0,1,0,1,... with no done.
//    Clear loop_en during entry 0 -> done after the following entry 1.
//  5 stop mid-PLAY with beep=1 -> next cycle beep=0, busy=0, done=0.
//    Next start resumes at cur_addr=0.
//  6 rst_n low mid-PLAY -> beep/busy/done/cur_addr 0 before the next clk edge. dur=0 entry -> LOAD then GAP only.

Source files
------------

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Programmable melody player for the buzzer. A small sequence RAM holds note
//   entries {oct_up, note[2:0], dur[DUR_W-1:0]}. Playback loads each entry,
//   drives a square wave at the note pitch for dur ticks, then stays silent
//   for GAP_TICKS ticks before moving on. Supports one-shot and loop modes.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wr_en      write wr_data into the sequence RAM at wr_addr
//   wr_addr    RAM write address
//   wr_data    note entry
//   last_addr  index of the final entry (sampled live)
//   loop_en    restart at entry 0 after last_addr (sampled at sequence end)
//   start      begin playback from entry 0 (pulse, ignored while busy)
//   stop       abort playback (pulse, wins over start)
//   busy       high from LOAD through the end of the sequence
//   done       one-cycle pulse on normal one-shot completion
//   cur_addr   entry currently loaded/playing
//   beep       square-wave buzzer drive
// -----------------------------------------------------------------------------
module tone_sequencer #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DUR_W     = 12,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_TICKS = 10,
  parameter int unsigned AW        = 4,
  localparam int unsigned EW       = 4 + DUR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] last_addr,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_addr,
  output logic          beep
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // Sequence RAM: not reset, read asynchronously during LOAD so that a write
  // landing on the same edge is seen only at the following LOAD.
  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  logic [1:0]       state_q,    state_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [DIV_W-1:0] half_q,     half_d;
  logic [DUR_W-1:0] dur_q,      dur_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q,  dur_cnt_d;
  logic             beep_q,     beep_d;
  logic             done_q,     done_d;

  logic [EW-1:0]    entry;
  logic             ent_oct;
  logic [2:0]       ent_note;
  logic [DUR_W-1:0] ent_dur;
  logic [DIV_W-1:0] base_half;
  logic [DIV_W-1:0] ent_half;
  logic             tick;
  logic             finish;

  assign entry    = mem_q[cur_addr_q];
  assign ent_oct  = entry[EW-1];
  assign ent_note = entry[EW-2 -: 3];
  assign ent_dur  = entry[DUR_W-1:0];

  always_comb begin
    base_half = '0;
    case (ent_note)
      3'd1:    base_half = DIV_W'(47774);
      3'd2:    base_half = DIV_W'(42568);
      3'd3:    base_half = DIV_W'(37919);
      3'd4:    base_half = DIV_W'(35791);
      3'd5:    base_half = DIV_W'(31888);
      3'd6:    base_half = DIV_W'(28410);
      3'd7:    base_half = DIV_W'(25309);
      default: base_half = '0;
    endcase
  end

  // A rest has half-period 0, so the octave shift leaves it silent.
  assign ent_half = ent_oct ? (base_half >> 1) : base_half;
  assign tick     = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    half_d     = half_q;
    dur_d      = dur_q;
    cnt_d      = cnt_q;
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    beep_d     = 1'b0;
    done_d     = 1'b0;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          cur_addr_d = '0;
        end
      end

      S_LOAD: begin
        half_d     = ent_half;
        dur_d      = ent_dur;
        cnt_d      = '0;
        tick_cnt_d = '0;
        dur_cnt_d  = '0;
        if (ent_dur == '0) begin
          if (GAP_TICKS == 0) finish = 1'b1;
          else                state_d = S_GAP;
        end else begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        beep_d = beep_q;
        if (half_q != '0) begin
          if (cnt_q == half_q - DIV_W'(1)) begin
            beep_d = ~beep_q;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        if (tick) begin
          tick_cnt_d = '0;
          if (dur_cnt_q == dur_q - DUR_W'(1)) begin
            beep_d    = 1'b0;
            cnt_d     = '0;
            dur_cnt_d = '0;
            if (GAP_TICKS == 0) finish = 1'b1;
            else                state_d = S_GAP;
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

      S_GAP: begin
        if (tick) begin
          tick_cnt_d = '0;
          if (dur_cnt_q == GAP_LAST) begin
            dur_cnt_d = '0;
            finish    = 1'b1;
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // End of a note, reached from LOAD, PLAY or GAP depending on dur/GAP_TICKS.
    if (finish) begin
      if (cur_addr_q != last_addr) begin
        cur_addr_d = cur_addr_q + AW'(1);
        state_d    = S_LOAD;
      end else if (loop_en) begin
        cur_addr_d = '0;
        state_d    = S_LOAD;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      beep_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      half_q     <= '0;
      dur_q      <= '0;
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      beep_q     <= beep_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign cur_addr = cur_addr_q;
  assign beep     = beep_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  last_addr;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [3:0]  cur_addr;
  logic        beep;

  int n_cmp = 0;
  int n_err = 0;

  tone_sequencer #(
    .TICK_DIV (100),
    .GAP_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_addr(last_addr),
    .loop_en  (loop_en),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .cur_addr (cur_addr),
    .beep     (beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ent(input logic o, input int note, input int dur);
    logic [2:0]  n3;
    logic [11:0] d12;
    n3  = note[2:0];
    d12 = dur[11:0];
    return {o, n3, d12};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a[3:0];
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts samples with busy high (first sample is the LOAD cycle).
  task automatic busy_len(output int n, output int dones, output int beeps);
    n = 0; dones = 0; beeps = 0;
    while (busy === 1'b1 && n < 20000) begin
      if (done !== 1'b0) dones++;
      if (beep !== 1'b0) beeps++;
      step();
      n++;
    end
  endtask

  task automatic wait_beep(input logic lvl, output int n);
    n = 0;
    while (beep !== lvl && n < 60000) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, dn, bp;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_addr = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

    #22;
    chk("reset_beep", beep, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cur_addr", cur_addr, 0);
    step();
    rst_n = 1'b1;
    step();

    // One-shot note 1, dur 3: pitch too low to toggle within 300 cycles.
    wr(0, ent(1'b0, 1, 3));
    pulse_start();
    chk("t1_busy_after_start", busy, 1);
    chk("t1_cur_addr", cur_addr, 0);
    busy_len(n, dn, bp);
    chk("t1_busy_cycles", n, 501);
    chk("t1_no_beep", bp, 0);
    chk("t1_no_early_done", dn, 0);
    chk("t1_done_at_busy_fall", done, 1);
    step();
    chk("t1_done_one_cycle", done, 0);

    // Write colliding with the LOAD read returns old data; new data next time.
    wr(0, ent(1'b0, 0, 1));
    pulse_start();
    wr(0, ent(1'b0, 0, 3));
    busy_len(n, dn, bp);
    chk("t2_old_data_cycles", n + 1, 301);
    pulse_start();
    busy_len(n, dn, bp);
    chk("t2_new_data_cycles", n, 501);

    // Rest entry: silent for the whole note, single done pulse.
    wr(0, ent(1'b1, 0, 5));
    pulse_start();
    busy_len(n, dn, bp);
    chk("t3_rest_cycles", n, 701);
    chk("t3_rest_silent", bp, 0);
    chk("t3_rest_no_early_done", dn, 0);
    chk("t3_rest_done", done, 1);
    step();
    chk("t3_rest_done_once", done, 0);

    // Loop over two entries, then drop loop_en during entry 0.
    wr(0, ent(1'b0, 0, 1));
    wr(1, ent(1'b0, 0, 1));
    last_addr = 4'd1;
    loop_en   = 1'b1;
    pulse_start();
    chk("t4_first_addr", cur_addr, 0);
    repeat (301) step();
    chk("t4_second_addr", cur_addr, 1);
    chk("t4_no_done_a", done, 0);
    repeat (301) step();
    chk("t4_wrap_addr", cur_addr, 0);
    chk("t4_wrap_busy", busy, 1);
    chk("t4_no_done_b", done, 0);
    loop_en = 1'b0;
    repeat (301) step();
    chk("t4_final_addr", cur_addr, 1);
    chk("t4_final_busy", busy, 1);
    repeat (300) step();
    chk("t4_still_busy", busy, 1);
    chk("t4_not_done_yet", done, 0);
    step();
    chk("t4_end_busy", busy, 0);
    chk("t4_end_done", done, 1);
    step();

    // dur=0 entry 0 then octave-up note 7 at entry 1; stop while beep high.
    wr(0, ent(1'b0, 0, 0));
    wr(1, ent(1'b1, 7, 260));
    pulse_start();
    wait_beep(1'b1, n);
    chk("t5_oct_first_rise", n, 12856);
    chk("t5_addr_playing", cur_addr, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_stop_beep", beep, 0);
    chk("t5_stop_busy", busy, 0);
    chk("t5_stop_done", done, 0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_stop_beats_start", busy, 0);

    // Restart from 0; rewrite entry 1 while entry 0 is in progress.
    pulse_start();
    chk("t6_restart_addr", cur_addr, 0);
    chk("t6_restart_busy", busy, 1);
    wr(1, ent(1'b0, 7, 260));
    wait_beep(1'b1, n);
    chk("t6_first_rise", n + 1, 25511);
    chk("t6_addr_playing", cur_addr, 1);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_beep", beep, 0);
    chk("t7_async_busy", busy, 0);
    chk("t7_async_done", done, 0);
    chk("t7_async_cur_addr", cur_addr, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t7_idle_after_reset", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
